// File: rtl/ntt_butterfly_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : ntt_butterfly_addr_gen
// Description : Radix-2 Cooley-Tukey butterfly address sequencer. After the
//               coefficients are loaded into two half-size banks (low bank
//               holds indices < RING_SIZE/2), it walks every NTT stage and
//               emits, per butterfly, the bank/address of both operands and
//               the twiddle ROM index on a valid/ready stream. A programmable
//               idle gap separates stages so that write-backs of one stage
//               land before the next stage reads them.
// Ports       : clk        - clock, all state updates on posedge
//               reset      - synchronous, active-high
//               start      - load complete, sampled only in IDLE
//               out_ready  - datapath accepts the current pair
//               out_valid  - pair outputs valid
//               bank_a/b   - operand bank (0 = low, 1 = high)
//               addr_a/b   - operand address within its bank
//               tw_idx     - twiddle ROM index
//               stage      - current stage 0..LOG-1
//               last_pair  - current pair is the last of its stage
//               busy       - sequencing a transform (RUN or GAP)
//               done       - one-cycle pulse after the final pair is taken
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_butterfly_addr_gen #(
    parameter int RING_SIZE = 256,
    parameter int STAGE_GAP = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic                           bank_a,
    output logic [$clog2(RING_SIZE)-2:0]   addr_a,
    output logic                           bank_b,
    output logic [$clog2(RING_SIZE)-2:0]   addr_b,
    output logic [$clog2(RING_SIZE)-2:0]   tw_idx,
    output logic [$clog2(RING_SIZE)-1:0]   stage,
    output logic                           last_pair,
    output logic                           busy,
    output logic                           done
);

    localparam int c_LOG   = $clog2(RING_SIZE);
    localparam int c_GAP_W = (STAGE_GAP > 0) ? $clog2(STAGE_GAP + 1) : 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_GAP  = 2'd2;
    localparam logic [1:0] c_S_FIN  = 2'd3;

    localparam logic [c_LOG-1:0]   c_STAGE_ONE  = c_LOG'(1);
    localparam logic [c_LOG-1:0]   c_STAGE_LAST = c_LOG'(c_LOG - 1);
    localparam logic [c_LOG-2:0]   c_PAIR_ONE   = (c_LOG-1)'(1);
    // N/2-1 is all ones in an N/2 counter
    localparam logic [c_LOG-2:0]   c_PAIR_LAST  = '1;
    localparam logic [c_GAP_W-1:0] c_GAP_INIT   = c_GAP_W'(STAGE_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE    = c_GAP_W'(1);

    logic [1:0]         r_state;
    logic [c_LOG-1:0]   r_stage;
    logic [c_LOG-2:0]   r_pair;
    logic [c_GAP_W-1:0] r_gap;

    logic               w_valid;
    logic [c_LOG-2:0]   w_one_p;
    logic [c_LOG-2:0]   w_mask;
    logic [c_LOG-2:0]   w_off;
    logic [c_LOG-2:0]   w_grp;
    logic [c_LOG-1:0]   w_len;
    logic [c_LOG-1:0]   w_a;
    logic [c_LOG-1:0]   w_b;
    logic [c_LOG-2:0]   w_tw;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_stage <= '0;
            r_pair  <= '0;
            r_gap   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state <= c_S_RUN;
                        r_stage <= '0;
                        r_pair  <= '0;
                    end
                end
                c_S_RUN: begin
                    // out_valid is always high here, so ready alone means a fire
                    if (out_ready) begin
                        if (r_pair != c_PAIR_LAST) begin
                            r_pair <= r_pair + c_PAIR_ONE;
                        end else if (r_stage != c_STAGE_LAST) begin
                            if (STAGE_GAP > 0) begin
                                r_state <= c_S_GAP;
                                r_gap   <= c_GAP_INIT;
                            end else begin
                                r_stage <= r_stage + c_STAGE_ONE;
                                r_pair  <= '0;
                            end
                        end else begin
                            r_state <= c_S_FIN;
                        end
                    end
                end
                c_S_GAP: begin
                    r_gap <= r_gap - c_GAP_ONE;
                    // the cycle the counter reads 1 is the last idle cycle
                    if (r_gap == c_GAP_ONE) begin
                        r_state <= c_S_RUN;
                        r_stage <= r_stage + c_STAGE_ONE;
                        r_pair  <= '0;
                    end
                end
                c_S_FIN: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pair arithmetic: len = 1<<s, offset = p mod len, group = p / len.
    // a = group*2*len + offset, b = a + len, tw = offset << (LOG-1-s).
    // ------------------------------------------------------------------------
    assign w_valid = (r_state == c_S_RUN);
    assign w_one_p = c_PAIR_ONE;
    // at s = LOG-1 the shift overflows to 0 and the subtraction gives all ones,
    // which is exactly len-1 in LOG-1 bits
    assign w_mask  = (w_one_p << r_stage) - w_one_p;
    assign w_off   = r_pair & w_mask;
    assign w_grp   = r_pair >> r_stage;
    assign w_len   = c_STAGE_ONE << r_stage;
    assign w_a     = ({1'b0, w_grp} << (r_stage + c_STAGE_ONE)) | {1'b0, w_off};
    assign w_b     = w_a + w_len;
    assign w_tw    = w_off << (c_STAGE_LAST - r_stage);

    assign out_valid = w_valid;
    assign bank_a    = w_valid & w_a[c_LOG-1];
    assign addr_a    = w_valid ? w_a[c_LOG-2:0] : '0;
    assign bank_b    = w_valid & w_b[c_LOG-1];
    assign addr_b    = w_valid ? w_b[c_LOG-2:0] : '0;
    assign tw_idx    = w_valid ? w_tw : '0;
    assign last_pair = w_valid & (r_pair == c_PAIR_LAST);
    assign stage     = r_stage;
    assign busy      = (r_state == c_S_RUN) | (r_state == c_S_GAP);
    assign done      = (r_state == c_S_FIN);

endmodule
`default_nettype wire
